dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer that shares the single-port data memory between the pipeline MEM stage (port 0) and a secondary master such as a DMA/loader engine (port 1). Requests are latched, arbitrated round-robin, and issued to the memory for one access cycle. Completion is returned as a registered one-cycle ack with read data. Out-of-range word addresses are rejected with an error flag, and the memory is never written for them.

## Interface
Parameters:
- ADDR_BITS, 8, word-index bits decoded by the data memory; valid byte addresses have addr[31:ADDR_BITS+2] == 0

Ports:
- clk  in  1  single clock, all state updates on posedge
- reset  in  1  synchronous, active-low (0 = reset)
- p0_req  in  1  port 0 request, held until p0_ack
- p0_we  in  1  1 = write, 0 = read
- p0_addr  in  32  byte address; bits [1:0] ignored
- p0_wdata  in  32  write data
- p0_ack  out  1  one-cycle completion pulse
- p0_err  out  1  valid with p0_ack: address out of range
- p0_rdata  out  32  read data, valid with p0_ack, held until the next p0 read ack
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_err, p1_rdata: same as port 0
- mem_addr  out  32  to memory Address
- mem_wdata  out  32  to memory Write_Data
- mem_read  out  1  to memory read enable
- mem_write  out  1  to memory write enable
- mem_rdata  in  32  combinational read data from memory

## Operation
- States: IDLE, ACCESS.
- IDLE:
  - Eligible port = req high AND its ack not high this cycle. This masks the requester's drop cycle.
  - If exactly one port is eligible, it wins.
  - If both are eligible, the port != last_grant wins.
  - The winner's we, addr, wdata, and index are latched, last_grant <= winner, and the state moves to ACCESS.
  - Range check on the latched address: err_lat = |addr[31:ADDR_BITS+2].
- ACCESS:
  - mem_addr and mem_wdata are driven from the latches.
  - mem_read = !we_lat & !err_lat.
  - mem_write = we_lat & !err_lat & reset. The write is gated by reset so that a reset edge never commits a write.
  - At the closing edge:
    - Winner's ack <= 1.
    - Winner's err <= err_lat.
    - For a read, winner's rdata <= err_lat ? 0 : mem_rdata.
    - For a write, rdata is unchanged.
    - State <= IDLE.
- Outside ACCESS: mem_read = mem_write = 0; mem_addr and mem_wdata hold their last latched values.
- ack and err are cleared on the next edge; they are high for exactly one cycle.
- Requester rule: deassert req, or present a new request, in the cycle after observing ack. The arbiter ignores that port's req during its ack cycle.
- Reset (reset == 0 at a posedge):
  - state <= IDLE, last_grant <= 1 (port 0 wins the first tie).
  - All latches, acks, errs, rdata <= 0.
  - Reset during ACCESS abandons the transaction: no ack and no memory write.

## Timing
- Request sampled at edge E0 (IDLE); memory access occurs in cycle E0..E1; ack and rdata are visible in the cycle after E1.
- Latency from req to ack is 2 cycles.
- Throughput is one access per 2 cycles. With both ports requesting continuously, grants alternate 0,1,0,1.
- The ack cycle of one port is an IDLE cycle in which the other port may win. There is no bubble between alternating grants beyond the IDLE cycle.
- A write is visible to a read that is granted later: the write commits at E1, and any later read samples memory at E1+2 or after.
- Reset values:
  - p*_ack = p*_err = 0, p*_rdata = 0.
  - mem_addr = mem_wdata = 0, mem_read = mem_write = 0.

## Structure
- Package dmem_arb_pkg:
  - state enum {IDLE, ACCESS}
  - port index constants PORT_CPU = 0, PORT_AUX = 1
- Optional sub-module rr_select2: inputs eligible[1:0] and last_grant; outputs winner index and a valid flag; purely combinational.
- The FSM, latches and output registers stay in dmem_arbiter.

## Test plan
- Reset then single write then read:
  - Apply reset low for 2 cycles, all outputs 0.
  - p0 write 0x0000_0010 ← 0xDEAD_BEEF: p0_ack 2 cycles after req, p0_err = 0.
  - p0 read 0x10: p0_rdata = 0xDEAD_BEEF with ack.
- Simultaneous first requests: p0 and p1 both assert reads at the first cycle after reset. p0 is acked first, p1 two cycles later, with no overlap of mem_read between ports.
- Sustained contention: both ports request back-to-back for 8 accesses each. Grants alternate strictly, each port receives 8 acks, and no duplicate access occurs on an ack cycle.
- Out-of-range access: p1 writes to address 0x0000_0400 (ADDR_BITS = 8). p1_ack = 1 with p1_err = 1, mem_write is never 1, and a subsequent read of word 0 is unchanged.
- Reset mid-access: reset is pulled low during ACCESS of a p0 write. There is no p0_ack, mem_write is 0 at that edge, the memory content is unchanged, and the state is IDLE afterwards.
- Read-after-write across ports: p0 writes 0x20 ← 0x1234_5678, then p1 reads 0x20 while requesting concurrently. p1_rdata = 0x1234_5678.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-port data-memory arbiter.
// Holds the sequencer state encoding and the port index constants.
// Imported by dmem_arbiter and rr_select2.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_select2.sv
// Two-way round-robin pick between the eligible requesters.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when a pick is consumed.
module rr_select2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] eligible_i,
  input  logic       last_grant_i,
  output logic       winner_o,
  output logic       valid_o
);

  // Sole eligible port wins; on a tie the port not granted last time wins.
  always_comb begin
    valid_o  = |eligible_i;
    winner_o = PORT_CPU;
    if (&eligible_i) begin
      winner_o = ~last_grant_i;
    end else if (eligible_i[1]) begin
      winner_o = PORT_AUX;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the MEM stage (port 0) and an aux master (port 1).
// Latency: request sampled in IDLE, memory accessed next cycle, ack + rdata two cycles after req.
// Backpressure: req is held until ack; a port's req is ignored during its own ack cycle.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  state_e      state_q;
  logic        last_grant_q;
  logic        idx_q;
  logic        we_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        p0_ack_q;
  logic        p0_err_q;
  logic [31:0] p0_rdata_q;
  logic        p1_ack_q;
  logic        p1_err_q;
  logic [31:0] p1_rdata_q;

  logic [1:0]  elig;
  logic        sel_idx;
  logic        sel_vld;
  logic        win_we;
  logic        win_err;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic        in_access;

  // A port that is being acked this cycle is still holding the old req; mask it.
  assign elig = {p1_req & ~p1_ack_q, p0_req & ~p0_ack_q};

  rr_select2 u_sel (
    .eligible_i   (elig),
    .last_grant_i (last_grant_q),
    .winner_o     (sel_idx),
    .valid_o      (sel_vld)
  );

  assign win_we    = (sel_idx == PORT_AUX) ? p1_we    : p0_we;
  assign win_addr  = (sel_idx == PORT_AUX) ? p1_addr  : p0_addr;
  assign win_wdata = (sel_idx == PORT_AUX) ? p1_wdata : p0_wdata;
  // Any set bit above the decoded word index means the address misses the memory.
  assign win_err   = |win_addr[31:ADDR_BITS+2];

  assign in_access = (state_q == ACCESS);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read  = in_access & ~we_q & ~err_q;
  // Gating with reset keeps a reset edge that lands mid-access from committing the write.
  assign mem_write = in_access & we_q & ~err_q & reset;

  assign p0_ack   = p0_ack_q;
  assign p0_err   = p0_err_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_ack   = p1_ack_q;
  assign p1_err   = p1_err_q;
  assign p1_rdata = p1_rdata_q;

  // Sequencer: latch the winner in IDLE, complete it with a one-cycle ack after ACCESS.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_AUX;
      idx_q        <= PORT_CPU;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      p0_ack_q     <= 1'b0;
      p0_err_q     <= 1'b0;
      p0_rdata_q   <= '0;
      p1_ack_q     <= 1'b0;
      p1_err_q     <= 1'b0;
      p1_rdata_q   <= '0;
    end else begin
      p0_ack_q <= 1'b0;
      p0_err_q <= 1'b0;
      p1_ack_q <= 1'b0;
      p1_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sel_vld) begin
            idx_q        <= sel_idx;
            we_q         <= win_we;
            err_q        <= win_err;
            addr_q       <= win_addr;
            wdata_q      <= win_wdata;
            last_grant_q <= sel_idx;
            state_q      <= ACCESS;
          end
        end
        ACCESS: begin
          if (idx_q == PORT_CPU) begin
            p0_ack_q <= 1'b1;
            p0_err_q <= err_q;
            if (!we_q) p0_rdata_q <= err_q ? '0 : mem_rdata;
          end else begin
            p1_ack_q <= 1'b1;
            p1_err_q <= err_q;
            if (!we_q) p1_rdata_q <= err_q ? '0 : mem_rdata;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic.
// Expected data come from a word-array model of memory updated in ack order.
// Each port's request stream is a queue of transactions served until acked.
module tb_dmem_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        init_mem = 1'b1;
  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [31:0] p0_addr = '0, p0_wdata = '0;
  logic        p1_req = 1'b0, p1_we = 1'b0;
  logic [31:0] p1_addr = '0, p1_wdata = '0;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  logic [31:0] tb_mem  [0:255];
  logic [31:0] ref_mem [0:255];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  txn_t q0[$];
  txn_t q1[$];
  int   start0, start1, lat0, lat1;
  logic [31:0] exp_rd0, exp_rd1;
  int   ack_port[$];
  int   ack_cyc[$];
  logic        acc_vld, acc_we;
  logic [31:0] acc_addr, acc_wdata;
  int   n_mem_acc, n_ok_ack;

  dmem_arbiter #(.ADDR_BITS(8)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port memory with a combinational read.
  assign mem_rdata = tb_mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (mem_write) begin
      tb_mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic txn_t mk(input logic we, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    return t;
  endfunction

  task automatic drive();
    p0_req = (q0.size() != 0);
    if (q0.size() != 0) begin
      p0_we = q0[0].we; p0_addr = q0[0].addr; p0_wdata = q0[0].wdata;
    end
    p1_req = (q1.size() != 0);
    if (q1.size() != 0) begin
      p1_we = q1[0].we; p1_addr = q1[0].addr; p1_wdata = q1[0].wdata;
    end
  endtask

  // Score one port for the current cycle against the memory model.
  task automatic port_check(input int p, input logic ack, input logic err, input logic [31:0] rdata);
    txn_t h;
    logic have, oor;
    have = (p == 0) ? (q0.size() != 0) : (q1.size() != 0);
    if (ack) begin
      if (!have) begin
        chk(p == 0 ? "p0_spurious_ack" : "p1_spurious_ack", {31'b0, ack}, 32'd0);
      end else begin
        h   = (p == 0) ? q0[0] : q1[0];
        oor = |h.addr[31:10];
        chk(p == 0 ? "p0_err" : "p1_err", {31'b0, err}, {31'b0, oor});
        if (!oor) begin
          chk("acc_before_ack", {31'b0, acc_vld}, 32'd1);
          chk("acc_word", {22'b0, acc_addr[9:2], 2'b0}, {22'b0, h.addr[9:2], 2'b0});
          chk("acc_dir", {31'b0, acc_we}, {31'b0, h.we});
          if (h.we) chk("acc_wdata", acc_wdata, h.wdata);
          n_ok_ack++;
        end else begin
          chk("oor_no_access", {31'b0, acc_vld}, 32'd0);
        end
        if (!h.we) begin
          if (p == 0) exp_rd0 = oor ? 32'd0 : ref_mem[h.addr[9:2]];
          else        exp_rd1 = oor ? 32'd0 : ref_mem[h.addr[9:2]];
        end else if (!oor) begin
          ref_mem[h.addr[9:2]] = h.wdata;
        end
        ack_port.push_back(p);
        ack_cyc.push_back(cyc);
        if (p == 0) begin lat0 = cyc - start0; start0 = cyc; void'(q0.pop_front()); end
        else        begin lat1 = cyc - start1; start1 = cyc; void'(q1.pop_front()); end
      end
    end
    chk(p == 0 ? "p0_rdata" : "p1_rdata", rdata, (p == 0) ? exp_rd0 : exp_rd1);
  endtask

  task automatic on_cycle();
    port_check(0, p0_ack, p0_err, p0_rdata);
    port_check(1, p1_ack, p1_err, p1_rdata);
    if (mem_read & mem_write) chk("rd_wr_overlap", 32'd1, 32'd0);
    if (mem_write) chk("write_in_range", {31'b0, |mem_addr[31:10]}, 32'd0);
    acc_vld   = mem_read | mem_write;
    acc_we    = mem_write;
    acc_addr  = mem_addr;
    acc_wdata = mem_wdata;
    if (acc_vld) n_mem_acc++;
  endtask

  task automatic run(input int budget);
    int n = 0;
    start0 = cyc; start1 = cyc; acc_vld = 1'b0;
    drive();
    while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
      tick();
      n++;
      on_cycle();
      drive();
    end
    chk("pending_at_budget", 32'(q0.size() + q1.size()), 32'd0);
    q0.delete(); q1.delete();
    drive();
  endtask

  task automatic do_reset();
    q0.delete(); q1.delete();
    drive();
    reset = 1'b0;
    tick(); tick();
    chk("rst_p0_ack", {31'b0, p0_ack}, 32'd0);
    chk("rst_p0_err", {31'b0, p0_err}, 32'd0);
    chk("rst_p0_rdata", p0_rdata, 32'd0);
    chk("rst_p1_ack", {31'b0, p1_ack}, 32'd0);
    chk("rst_p1_err", {31'b0, p1_err}, 32'd0);
    chk("rst_p1_rdata", p1_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    reset = 1'b1;
    exp_rd0 = '0;
    exp_rd1 = '0;
  endtask

  initial begin
    int t0, c0, c1;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
    exp_rd0 = '0; exp_rd1 = '0;

    // Reset, then an isolated write and read on port 0.
    do_reset();
    init_mem = 1'b0;
    q0.push_back(mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF));
    run(20);
    chk("p0_write_latency", 32'(lat0), 32'd2);
    tick();
    q0.push_back(mk(1'b0, 32'h0000_0010, 32'h0));
    run(20);
    chk("p0_read_latency", 32'(lat0), 32'd2);
    chk("p0_read_data", p0_rdata, 32'hDEAD_BEEF);

    // Simultaneous first requests after reset, then sustained contention (8 each).
    do_reset();
    q0.push_back(mk(1'b0, 32'h0000_0010, 32'h0));
    q1.push_back(mk(1'b0, 32'h0000_0014, 32'h0));
    for (int i = 0; i < 7; i++) begin
      q0.push_back(mk(1'($urandom_range(0, 1)), 32'($urandom_range(32, 63)) << 2, $urandom));
      q1.push_back(mk(1'($urandom_range(0, 1)), 32'($urandom_range(32, 63)) << 2, $urandom));
    end
    ack_port.delete(); ack_cyc.delete();
    n_mem_acc = 0; n_ok_ack = 0;
    t0 = cyc;
    run(100);
    chk("cont_ack_count", 32'(ack_port.size()), 32'd16);
    if (ack_port.size() == 16) begin
      chk("first_winner", 32'(ack_port[0]), 32'd0);
      chk("first_ack_latency", 32'(ack_cyc[0] - t0), 32'd2);
      c0 = 0; c1 = 0;
      for (int i = 0; i < 16; i++) begin
        if (ack_port[i] == 0) c0++; else c1++;
        if (i > 0) begin
          chk("alternate", 32'(ack_port[i]), 32'(1 - ack_port[i-1]));
          chk("ack_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd2);
        end
      end
      chk("p0_acks", 32'(c0), 32'd8);
      chk("p1_acks", 32'(c1), 32'd8);
    end
    chk("one_access_per_ack", 32'(n_mem_acc), 32'(n_ok_ack));

    // Out-of-range write aliases word 0 but must not touch memory.
    tick();
    q1.push_back(mk(1'b1, 32'h0000_0400, 32'hBAD0_BAD0));
    run(20);
    chk("oor_write_latency", 32'(lat1), 32'd2);
    q1.push_back(mk(1'b0, 32'h0000_0000, 32'h0));
    run(20);
    chk("word0_unchanged", p1_rdata, 32'hA500_0000);
    q0.push_back(mk(1'b0, 32'h1000_0010, 32'h0));
    run(20);
    chk("oor_read_zero", p0_rdata, 32'h0);

    // Reset while a port 0 write is in its access cycle.
    tick();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h0000_0030; p0_wdata = 32'hCAFE_F00D;
    tick();
    chk("mid_write_issued", {31'b0, mem_write}, 32'd1);
    reset = 1'b0;
    #1;
    chk("write_gated_by_reset", {31'b0, mem_write}, 32'd0);
    do_reset();
    tick();
    q0.push_back(mk(1'b0, 32'h0000_0030, 32'h0));
    run(20);
    chk("post_reset_latency", 32'(lat0), 32'd2);
    chk("abandoned_write", p0_rdata, 32'hA500_000C);

    // Read-after-write across ports with concurrent requests.
    do_reset();
    q0.push_back(mk(1'b1, 32'h0000_0020, 32'h1234_5678));
    q1.push_back(mk(1'b0, 32'h0000_0020, 32'h0));
    run(20);
    chk("raw_cross_port", p1_rdata, 32'h1234_5678);

    // Randomized mixed traffic on a small hot address set, some out of range.
    tick();
    for (int i = 0; i < 30; i++) begin
      a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0000_0400)
                                      : ((32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3)));
      q0.push_back(mk(1'($urandom_range(0, 1)), a, $urandom));
      a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0010_0000)
                                      : ((32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3)));
      q1.push_back(mk(1'($urandom_range(0, 1)), a, $urandom));
    end
    run(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
